// File: rtl/rename_unit_pkg.sv
// Shared rename types: architectural register space and the per-lane
// renamed-operand bundle used by rename, dispatch and the ROB.
package rename_unit_pkg;

    localparam int NUM_AREGS = 32;
    localparam int AREG_BITS = 5;
    localparam int PHYS_REG_BITS = 6;

    typedef logic [AREG_BITS-1:0] areg_t;
    typedef logic [PHYS_REG_BITS-1:0] preg_t;

    typedef struct packed {
        preg_t rs1;
        preg_t rs2;
        preg_t rd;
        preg_t old;
    } rename_lane_t;

endpackage

// File: rtl/rename_unit_free_list.sv
// Circular physical-register free list with a speculative pop head,
// a committed head for flush recovery, and an in-order push tail.
module rename_unit_free_list
    import rename_unit_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int NUM_PREGS = 64,
    localparam int PREG_BITS = $clog2(NUM_PREGS),
    localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [CNT_W-1:0]                pop_cnt,
    output logic [WIDTH-1:0][PREG_BITS-1:0] pop_paddr,
    input  logic [WIDTH-1:0]                push_v,
    input  logic [WIDTH-1:0][PREG_BITS-1:0] push_paddr,
    output logic [PREG_BITS:0]              count
);

    localparam int PTR_W = PREG_BITS + 1;
    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(FL_DEPTH);

    logic [PREG_BITS-1:0] mem_q [FL_DEPTH];
    logic [PREG_BITS-1:0] mem_d [FL_DEPTH];
    logic [PTR_W-1:0]     spec_head_q;
    logic [PTR_W-1:0]     spec_head_d;
    logic [PTR_W-1:0]     commit_head_q;
    logic [PTR_W-1:0]     commit_head_d;
    logic [PTR_W-1:0]     tail_q;
    logic [PTR_W-1:0]     tail_d;
    logic [CNT_W-1:0]     npush;

    function automatic logic [IDX_W-1:0] slot(input logic [PTR_W-1:0] p);
        return IDX_W'(p % DEPTH_P);
    endfunction

    // Every committed lane both frees its old register and retires one pop.
    always_comb begin
        mem_d = mem_q;
        npush = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (push_v[i]) begin
                mem_d[slot(tail_q + PTR_W'(npush))] = push_paddr[i];
                npush = npush + CNT_W'(1);
            end
        end
        tail_d = tail_q + PTR_W'(npush);
        commit_head_d = commit_head_q + PTR_W'(npush);
        spec_head_d = flush ? commit_head_d
                            : spec_head_q + PTR_W'(pop_cnt);
    end

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            pop_paddr[k] = mem_q[slot(spec_head_q + PTR_W'(k))];
        end
    end

    assign count = tail_q - spec_head_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PREG_BITS'(NUM_AREGS + i);
            end
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= DEPTH_P;
        end else begin
            mem_q         <= mem_d;
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n) count <= DEPTH_P);
    a_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n) PTR_W'(pop_cnt) <= count);

endmodule

// File: rtl/rename_unit.sv
// WIDTH-wide register rename: speculative RAT, retirement RAT, intra-group
// bypass, commit-driven register release and single-cycle flush recovery.
module rename_unit
    import rename_unit_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int NUM_PREGS = 64,
    localparam int PREG_BITS = $clog2(NUM_PREGS),
    localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                in_lane_v,
    input  logic [WIDTH-1:0][AREG_BITS-1:0] in_rd,
    input  logic [WIDTH-1:0][AREG_BITS-1:0] in_rs1,
    input  logic [WIDTH-1:0][AREG_BITS-1:0] in_rs2,
    output logic                            in_ready,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_lane_v,
    output logic [WIDTH-1:0][PREG_BITS-1:0] out_rs1_paddr,
    output logic [WIDTH-1:0][PREG_BITS-1:0] out_rs2_paddr,
    output logic [WIDTH-1:0][PREG_BITS-1:0] out_rd_paddr,
    output logic [WIDTH-1:0][PREG_BITS-1:0] out_old_paddr,
    input  logic                            out_ready,
    input  logic [WIDTH-1:0]                commit_v,
    input  logic [WIDTH-1:0][AREG_BITS-1:0] commit_rd,
    input  logic [WIDTH-1:0][PREG_BITS-1:0] commit_paddr,
    input  logic [WIDTH-1:0][PREG_BITS-1:0] commit_old_paddr,
    input  logic                            flush,
    output logic [PREG_BITS:0]              fl_count
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PTR_W = PREG_BITS + 1;

    logic [PREG_BITS-1:0] rat_q  [NUM_AREGS];
    logic [PREG_BITS-1:0] rat_d  [NUM_AREGS];
    logic [PREG_BITS-1:0] rrat_q [NUM_AREGS];
    logic [PREG_BITS-1:0] rrat_d [NUM_AREGS];

    logic                            out_valid_q, out_valid_d;
    logic [WIDTH-1:0]                out_lane_v_q, out_lane_v_d;
    logic [WIDTH-1:0][PREG_BITS-1:0] out_rs1_q, out_rs1_d;
    logic [WIDTH-1:0][PREG_BITS-1:0] out_rs2_q, out_rs2_d;
    logic [WIDTH-1:0][PREG_BITS-1:0] out_rd_q, out_rd_d;
    logic [WIDTH-1:0][PREG_BITS-1:0] out_old_q, out_old_d;

    logic [WIDTH-1:0]                need_v;
    logic [CNT_W-1:0]                need_cnt;
    logic [WIDTH-1:0][PREG_BITS-1:0] rs1_p, rs2_p, rd_p, old_p;
    logic [WIDTH-1:0][PREG_BITS-1:0] fl_pop_paddr;
    logic [WIDTH-1:0]                fl_push_v;
    logic [CNT_W-1:0]                fl_pop_cnt;
    logic                            accept;

    // Later lanes see earlier lanes' new mappings; the youngest writer wins.
    always_comb begin
        need_v   = '0;
        need_cnt = '0;
        rs1_p    = '0;
        rs2_p    = '0;
        rd_p     = '0;
        old_p    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            need_v[i] = in_lane_v[i] && (in_rd[i] != '0);
            rs1_p[i]  = rat_q[in_rs1[i]];
            rs2_p[i]  = rat_q[in_rs2[i]];
            if (need_v[i]) begin
                old_p[i] = rat_q[in_rd[i]];
                rd_p[i]  = fl_pop_paddr[need_cnt];
            end
            for (int k = 0; k < i; k++) begin
                if (need_v[k]) begin
                    if (in_rs1[i] == in_rd[k]) rs1_p[i] = rd_p[k];
                    if (in_rs2[i] == in_rd[k]) rs2_p[i] = rd_p[k];
                    if (need_v[i] && in_rd[i] == in_rd[k]) old_p[i] = rd_p[k];
                end
            end
            if (need_v[i]) need_cnt = need_cnt + CNT_W'(1);
        end
    end

    assign in_ready = (~out_valid_q | out_ready)
                    & (fl_count >= PTR_W'(need_cnt))
                    & ~flush;
    assign accept = in_valid & in_ready;
    assign fl_pop_cnt = accept ? need_cnt : '0;

    always_comb begin
        rrat_d    = rrat_q;
        fl_push_v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (commit_v[i] && commit_rd[i] != '0) begin
                rrat_d[commit_rd[i]] = commit_paddr[i];
                fl_push_v[i] = 1'b1;
            end
        end
        rat_d = rat_q;
        if (flush) begin
            rat_d = rrat_d;
        end else if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (need_v[i]) rat_d[in_rd[i]] = rd_p[i];
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_lane_v_d = out_lane_v_q;
        out_rs1_d    = out_rs1_q;
        out_rs2_d    = out_rs2_q;
        out_rd_d     = out_rd_q;
        out_old_d    = out_old_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_lane_v_d = '0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            out_lane_v_d = in_lane_v;
            out_rs1_d    = rs1_p;
            out_rs2_d    = rs2_p;
            out_rd_d     = rd_p;
            out_old_d    = old_p;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
            out_lane_v_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_AREGS; i++) begin
                rat_q[i]  <= PREG_BITS'(i);
                rrat_q[i] <= PREG_BITS'(i);
            end
            out_valid_q  <= 1'b0;
            out_lane_v_q <= '0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
            out_rd_q     <= '0;
            out_old_q    <= '0;
        end else begin
            rat_q        <= rat_d;
            rrat_q       <= rrat_d;
            out_valid_q  <= out_valid_d;
            out_lane_v_q <= out_lane_v_d;
            out_rs1_q    <= out_rs1_d;
            out_rs2_q    <= out_rs2_d;
            out_rd_q     <= out_rd_d;
            out_old_q    <= out_old_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_lane_v    = out_lane_v_q;
    assign out_rs1_paddr = out_rs1_q;
    assign out_rs2_paddr = out_rs2_q;
    assign out_rd_paddr  = out_rd_q;
    assign out_old_paddr = out_old_q;

    rename_unit_free_list #(
        .WIDTH     (WIDTH),
        .NUM_PREGS (NUM_PREGS)
    ) u_free_list (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .pop_cnt    (fl_pop_cnt),
        .pop_paddr  (fl_pop_paddr),
        .push_v     (fl_push_v),
        .push_paddr (commit_old_paddr),
        .count      (fl_count)
    );

endmodule
